// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch front-panel data bundle: counter digits in,
// run/clear and display controls out.
interface stopwatch_ctrl_if;
  logic [15:0] live_data;
  logic        run;
  logic        sw_clear;
  logic [15:0] disp_data;
  logic [3:0]  digit_display;
  logic [3:0]  digit_point;

  modport master (
    input  live_data,
    output run,
    output sw_clear,
    output disp_data,
    output digit_display,
    output digit_point
  );

  modport slave (
    output live_data,
    input  run,
    input  sw_clear,
    input  disp_data,
    input  digit_display,
    input  digit_point
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: button debounce, run/lap FSM, display mux.
// Optional pause blink enabled by defining BLINK_ON_PAUSE_EN.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BLINK_ON_PAUSE_EN
  ,
  parameter int BLINK_CYCLES = 50000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_stop,
  input  logic btn_lap_reset,
  stopwatch_ctrl_if.master bus
);

  localparam int DBW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    LAP     = 2'd2,
    PAUSED  = 2'd3
  } state_t;

  // bit 0 = start/stop, bit 1 = lap/reset
  logic [1:0]     btn_raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     stable;
  logic [1:0]     press;
  logic [DBW-1:0] db_cnt [2];

  assign btn_raw = {btn_lap_reset, btn_start_stop};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      stable    <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
            press[i]  <= sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic   press_ss;
  logic   press_lr;
  state_t state;
  state_t state_nx;
  logic   clear_evt;
  logic   lap_load;

  assign press_ss = press[0];
  assign press_lr = press[1];

  // start/stop takes priority when both pulses coincide
  always_comb begin
    state_nx  = state;
    clear_evt = 1'b0;
    lap_load  = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_ss)      state_nx  = RUNNING;
        else if (press_lr) clear_evt = 1'b1;
      end
      RUNNING: begin
        if (press_ss) begin
          state_nx = PAUSED;
        end else if (press_lr) begin
          state_nx = LAP;
          lap_load = 1'b1;
        end
      end
      LAP: begin
        if (press_ss)      state_nx = PAUSED;
        else if (press_lr) state_nx = RUNNING;
      end
      PAUSED: begin
        if (press_ss) begin
          state_nx = RUNNING;
        end else if (press_lr) begin
          state_nx  = IDLE;
          clear_evt = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [15:0] lap_reg;
  logic [15:0] lap_nx;
  logic        run_q;
  logic        clr_q;
  logic [15:0] disp_q;
  logic [3:0]  point_q;

  assign lap_nx = lap_load ? bus.live_data : lap_reg;

  // Outputs are computed from the next state so they settle
  // together with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lap_reg <= '0;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      disp_q  <= '0;
      point_q <= 4'b0100;
    end else begin
      state   <= state_nx;
      lap_reg <= lap_nx;
      run_q   <= (state_nx == RUNNING) || (state_nx == LAP);
      clr_q   <= clear_evt;
      disp_q  <= (state_nx == LAP) ? lap_nx : bus.live_data;
      point_q <= (state_nx == LAP) ? 4'b0101 : 4'b0100;
    end
  end

  assign bus.run         = run_q;
  assign bus.sw_clear    = clr_q;
  assign bus.disp_data   = disp_q;
  assign bus.digit_point = point_q;

`ifdef BLINK_ON_PAUSE_EN
  localparam int BLW =
    (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLW-1:0] BL_MAX = BLW'(BLINK_CYCLES - 1);

  logic [BLW-1:0] blink_cnt;
  logic           blink_on;

  // Held at 0/on outside PAUSED so each entry starts a fresh on phase
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (state != PAUSED) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BL_MAX) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign bus.digit_display =
    ((state == PAUSED) && !blink_on) ? 4'b0000 : 4'b1111;
`else
  assign bus.digit_display = 4'b1111;
`endif

endmodule
